// File: rtl/sqm_pwm_sched.sv
// Time-division log-PWM scheduler: one output pin shared by the three SQMUSIC
// channels, each owning one SLOT_LEN-cycle slot of a 3*SLOT_LEN-cycle frame.
module sqm_pwm_sched #(
  parameter int SLOT_W = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [2:0] mute,
  output logic       pwm,
  output logic [1:0] slot,
  output logic       frame_start,
  output logic       busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_reg, state_next;
  logic [SLOT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]        slot_reg, slot_next;
  logic [3:0]        a_reg, a_next, b_reg, b_next, c_reg, c_next;
  logic [2:0]        mute_reg, mute_next;
  logic              pwm_reg, pwm_next;
  logic              fs_reg, fs_next;
  logic              busy_reg, busy_next;
  logic              load;
  logic [3:0]        level_sel;
  logic [SLOT_W:0]   duty_sel;

  // Log duty curve for a 64-clock slot; level 15 saturates to the full slot.
  function automatic logic [6:0] duty_base(input logic [3:0] lvl);
    case (lvl)
      4'd0:    duty_base = 7'd0;
      4'd1:    duty_base = 7'd1;
      4'd2:    duty_base = 7'd1;
      4'd3:    duty_base = 7'd1;
      4'd4:    duty_base = 7'd2;
      4'd5:    duty_base = 7'd2;
      4'd6:    duty_base = 7'd3;
      4'd7:    duty_base = 7'd4;
      4'd8:    duty_base = 7'd6;
      4'd9:    duty_base = 7'd8;
      4'd10:   duty_base = 7'd11;
      4'd11:   duty_base = 7'd16;
      4'd12:   duty_base = 7'd23;
      4'd13:   duty_base = 7'd32;
      4'd14:   duty_base = 7'd45;
      default: duty_base = 7'd64;
    endcase
  endfunction

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    slot_next  = slot_reg;
    busy_next  = busy_reg;
    fs_next    = 1'b0;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next  = '0;
        slot_next = 2'd0;
        busy_next = 1'b0;
        if (enable) begin
          load       = 1'b1;
          state_next = RUN;
          busy_next  = 1'b1;
          fs_next    = 1'b1;
        end
      end
      default: begin
        busy_next = 1'b1;
        cnt_next  = cnt_reg + 1'b1;
        if (&cnt_reg) begin
          if (slot_reg == 2'd2) begin
            slot_next = 2'd0;
            // Frame boundary: either relatch and continue, or drop to idle.
            if (enable) begin
              load    = 1'b1;
              fs_next = 1'b1;
            end else begin
              state_next = IDLE;
              busy_next  = 1'b0;
            end
          end else begin
            slot_next = slot_reg + 1'b1;
          end
        end
      end
    endcase

    a_next    = load ? A    : a_reg;
    b_next    = load ? B    : b_reg;
    c_next    = load ? C    : c_reg;
    mute_next = load ? mute : mute_reg;

    case (slot_next)
      2'd0:    level_sel = mute_next[0] ? 4'd0 : a_next;
      2'd1:    level_sel = mute_next[1] ? 4'd0 : b_next;
      default: level_sel = mute_next[2] ? 4'd0 : c_next;
    endcase
    duty_sel = (SLOT_W+1)'(duty_base(level_sel)) << (SLOT_W - 6);
    pwm_next = (state_next == RUN) && ({1'b0, cnt_next} < duty_sel);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      slot_reg  <= 2'd0;
      a_reg     <= 4'd0;
      b_reg     <= 4'd0;
      c_reg     <= 4'd0;
      mute_reg  <= 3'd0;
      pwm_reg   <= 1'b0;
      fs_reg    <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      slot_reg  <= slot_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      c_reg     <= c_next;
      mute_reg  <= mute_next;
      pwm_reg   <= pwm_next;
      fs_reg    <= fs_next;
      busy_reg  <= busy_next;
    end
  end

  assign pwm         = pwm_reg;
  assign slot        = slot_reg;
  assign frame_start = fs_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_sqm_pwm_sched.sv
// Directed bench for sqm_pwm_sched at SLOT_W=6 and SLOT_W=7.
module tb_sqm_pwm_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       en7;
  logic [3:0] A, B, C;
  logic [2:0] mute;
  logic       pwm, frame_start, busy;
  logic [1:0] slot;
  logic       pwm7, frame_start7, busy7;
  logic [1:0] slot7;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sqm_pwm_sched #(.SLOT_W(6)) dut (
    .clk(clk), .reset(reset), .enable(enable), .A(A), .B(B), .C(C), .mute(mute),
    .pwm(pwm), .slot(slot), .frame_start(frame_start), .busy(busy)
  );

  sqm_pwm_sched #(.SLOT_W(7)) dut7 (
    .clk(clk), .reset(reset), .enable(en7), .A(A), .B(B), .C(C), .mute(mute),
    .pwm(pwm7), .slot(slot7), .frame_start(frame_start7), .busy(busy7)
  );

  // Advances at least one cycle, then waits (bounded) for a frame_start pulse.
  task automatic wait_fs(input bit sel7, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if ((sel7 ? frame_start7 : frame_start) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit ok;
    reset = 1'b1; enable = 1'b0; en7 = 1'b0;
    A = 4'd15; B = 4'd15; C = 4'd15; mute = 3'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pwm, slot, frame_start, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_state: got %b required 00000", {pwm, slot, frame_start, busy});
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({frame_start, busy, pwm} !== 3'b000) begin
      errors++; $display("FAIL idle_quiet: got %b required 000", {frame_start, busy, pwm});
    end
    enable = 1'b1;
    wait_fs(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL first_frame: no frame_start seen, required one"); end
    repeat (100) @(negedge clk);
    checks++;
    if ({pwm, slot, busy} !== 4'b1011) begin
      errors++; $display("FAIL pre_reset_cycle100: got %b required 1011", {pwm, slot, busy});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pwm, slot, frame_start, busy} !== 5'b0) begin
      errors++; $display("FAIL async_reset: got %b required 00000", {pwm, slot, frame_start, busy});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({frame_start, busy} !== 2'b00) begin
      errors++; $display("FAIL post_release: got %b required 00", {frame_start, busy});
    end
    @(negedge clk);
    checks++;
    if ({frame_start, busy, slot, pwm} !== 5'b11001) begin
      errors++; $display("FAIL restart_frame: got %b required 11001", {frame_start, busy, slot, pwm});
    end
    $display("test_reset done");
  endtask

  task automatic test_levels(input logic [2:0] m, input int exp0, input int exp1, input int exp2);
    bit ok;
    int hi[3];
    int bad_pos, bad_slot, bad_fs;
    logic expb;
    A = 4'd15; B = 4'd0; C = 4'd8; mute = m;
    wait_fs(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL levels_fs: no frame_start seen, required one"); end
    hi = '{0, 0, 0}; bad_pos = 0; bad_slot = 0; bad_fs = 0;
    for (int i = 0; i < 192; i++) begin
      if (pwm === 1'b1) hi[i / 64]++;
      expb = m[0] ? ((i >= 128) && (i < 134)) : ((i < 64) || ((i >= 128) && (i < 134)));
      if (pwm !== expb) bad_pos++;
      if (slot !== 2'(i / 64)) bad_slot++;
      if (frame_start !== (i == 0)) bad_fs++;
      @(negedge clk);
    end
    checks++;
    if (hi[0] != exp0 || hi[1] != exp1 || hi[2] != exp2) begin
      errors++; $display("FAIL slot_high_counts: got %0d/%0d/%0d required %0d/%0d/%0d",
                         hi[0], hi[1], hi[2], exp0, exp1, exp2);
    end
    checks++;
    if (bad_pos != 0) begin errors++; $display("FAIL pwm_pattern: got %0d wrong cycles required 0", bad_pos); end
    checks++;
    if (bad_slot != 0) begin errors++; $display("FAIL slot_sequence: got %0d wrong cycles required 0", bad_slot); end
    checks++;
    if (bad_fs != 0) begin errors++; $display("FAIL fs_in_frame: got %0d wrong cycles required 0", bad_fs); end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++; $display("FAIL seamless_fs: got %b at cycle 192 required 1", frame_start);
    end
    $display("test_levels mute=%b: slot highs %0d/%0d/%0d", m, hi[0], hi[1], hi[2]);
  endtask

  task automatic test_midframe_change;
    bit ok;
    int hi0;
    A = 4'd15; B = 4'd0; C = 4'd0; mute = 3'd0;
    wait_fs(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL change_fs: no frame_start seen, required one"); end
    for (int f = 0; f < 2; f++) begin
      hi0 = 0;
      for (int i = 0; i < 192; i++) begin
        if (f == 0 && i == 10) A = 4'd1;
        if (i < 64 && pwm === 1'b1) hi0++;
        @(negedge clk);
      end
      checks++;
      if (hi0 != (f == 0 ? 64 : 1)) begin
        errors++; $display("FAIL change_frame%0d: got %0d high cycles required %0d", f, hi0, (f == 0 ? 64 : 1));
      end
    end
    $display("test_midframe_change done");
  endtask

  task automatic test_enable_drop;
    bit ok;
    int bad_busy, extra_fs;
    A = 4'd15; B = 4'd15; C = 4'd15; mute = 3'd0;
    wait_fs(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_fs: no frame_start seen, required one"); end
    bad_busy = 0; extra_fs = 0;
    for (int i = 0; i < 192; i++) begin
      if (i == 50) enable = 1'b0;
      if (busy !== 1'b1) bad_busy++;
      if (i > 0 && frame_start !== 1'b0) extra_fs++;
      @(negedge clk);
    end
    checks++;
    if (bad_busy != 0 || extra_fs != 0) begin
      errors++; $display("FAIL drop_full_frame: got busy_low=%0d extra_fs=%0d required 0/0", bad_busy, extra_fs);
    end
    checks++;
    if ({busy, pwm, slot, frame_start} !== 5'b0) begin
      errors++; $display("FAIL drop_idle: got %b required 00000", {busy, pwm, slot, frame_start});
    end
    extra_fs = 0;
    for (int i = 0; i < 400; i++) begin
      if (frame_start !== 1'b0 || busy !== 1'b0) extra_fs++;
      @(negedge clk);
    end
    checks++;
    if (extra_fs != 0) begin errors++; $display("FAIL drop_stays_idle: got %0d active cycles required 0", extra_fs); end
    $display("test_enable_drop done");
  endtask

  task automatic test_slotw7;
    bit ok;
    int hi0, bad_pos, bad_slot, bad_fs;
    A = 4'd10; B = 4'd0; C = 4'd0; mute = 3'd0;
    en7 = 1'b1;
    wait_fs(1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL w7_fs: no frame_start seen, required one"); end
    hi0 = 0; bad_pos = 0; bad_slot = 0; bad_fs = 0;
    for (int i = 0; i < 384; i++) begin
      if (pwm7 === 1'b1) hi0++;
      if (pwm7 !== (i < 22)) bad_pos++;
      if (slot7 === 2'd3 || slot7 !== 2'(i / 128)) bad_slot++;
      if (frame_start7 !== (i == 0)) bad_fs++;
      @(negedge clk);
    end
    checks++;
    if (hi0 != 22 || bad_pos != 0) begin
      errors++; $display("FAIL w7_duty: got %0d high (%0d misplaced) required 22 (0)", hi0, bad_pos);
    end
    checks++;
    if (bad_slot != 0) begin errors++; $display("FAIL w7_slot: got %0d wrong cycles required 0", bad_slot); end
    checks++;
    if (bad_fs != 0 || frame_start7 !== 1'b1) begin
      errors++; $display("FAIL w7_frame_len: got misplaced=%0d fs@384=%b required 0/1", bad_fs, frame_start7);
    end
    en7 = 1'b0;
    $display("test_slotw7 done: slot0 high %0d of 128", hi0);
  endtask

  initial begin
    test_reset();
    test_levels(3'b000, 64, 0, 6);
    test_levels(3'b001, 0, 0, 6);
    test_midframe_change();
    test_enable_drop();
    test_slotw7();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sqm_pwm_sched.md
Name: sqm_pwm_sched

Overview:
- Time-division scheduler that shares one logarithmic PWM output pin between the three 4-bit SQMUSIC channels (A, B, C).
- Each frame is split into three equal slots, one per channel. Within its slot, a channel's level is converted through a fixed log duty table into a high-time count.
- Levels are latched once per frame, so a frame is always coherent.
- Sits between the SQMUSIC tone/volume outputs and the board audio pin. Replaces OR-ing of per-channel PWMs with non-overlapping slots.

Parameters:
- SLOT_W, 6, log2 of slot length in clocks; SLOT_LEN = 2^SLOT_W; legal range 6..10.

Ports:
- clk  in  1  VHF system clock (>33 MHz)
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run request; sampled at frame boundaries only
- A  in  4  channel A level
- B  in  4  channel B level
- C  in  4  channel C level
- mute  in  3  per-channel mute (bit0=A, bit1=B, bit2=C), latched with levels
- pwm  out  1  shared PWM output
- slot  out  2  current slot index (0=A, 1=B, 2=C); never 3
- frame_start  out  1  one-cycle pulse on first cycle of each frame
- busy  out  1  high while a frame is in progress

Behaviour:
- Clocking and reset: single clock `clk`. Reset is asynchronous and active-high. All state is cleared immediately on reset assertion, including mid-frame.
- Reset values: pwm=0, slot=0, frame_start=0, busy=0, cnt=0, shadow levels=0, shadow mute=0, state=IDLE.
- State IDLE: outputs at their reset values. If enable=1 on a rising edge, go to RUN on that edge and latch A, B, C, mute into shadow registers (load edge).
- Registered RUN outputs on the cycle after the load edge: frame_start=1, busy=1, slot=0, cnt=0, pwm=(duty(A')>0). A' is the shadowed A, forced to 0 if its mute bit is set.
- RUN per cycle:
  - cnt increments modulo SLOT_LEN.
  - pwm = (cnt < duty(level of current slot)), registered and aligned with slot/cnt.
  - When cnt wraps, slot advances 0→1→2.
- End of frame (slot=2, cnt=SLOT_LEN-1):
  - enable=1: relatch inputs on the same edge and start the next frame seamlessly, with no idle cycle and frame_start=1 again.
  - enable=0: return to IDLE; next cycle pwm=0, busy=0, slot=0.
- Frame length is exactly 3*SLOT_LEN cycles.
- Input changes to A/B/C/mute during a frame have no effect until the next load edge.
- Deasserting enable mid-frame never truncates the frame.
- Duty table at SLOT_W=6, level 0..15: 0,1,1,1,2,2,3,4,6,8,11,16,23,32,45,64.
  - For SLOT_W>6, duty = table << (SLOT_W-6).
  - Compare width is SLOT_W+1 bits so that duty=SLOT_LEN (level 15) is representable.
- Level 15 gives pwm high for the whole slot. Level 0 or muted gives pwm low for the whole slot. There is no glitch at slot boundaries beyond the registered transition.
- frame_start is high for exactly one cycle per frame and is never asserted in IDLE.

Test Plan:
- Reset mid-frame: assert reset at cycle 100 of a frame → pwm, busy, slot, frame_start go 0 immediately (asynchronously). After release with enable=1, the first frame_start occurs 2 edges after reset deassertion.
- SLOT_W=6, A=15, B=0, C=8, mute=0, enable held 1 → pwm high cycles 0..63 (slot 0), low for all of slot 1, high cycles 128..133 (6 cycles) of slot 2. frame_start pulses every 192 cycles with no gap.
- Same levels with mute=3'b001 → slot 0 fully low; slots 1 and 2 unchanged.
- Change A from 15 to 1 at frame cycle 10 → current frame still shows 64 high cycles in slot 0; next frame shows exactly 1.
- Drop enable at frame cycle 50 → frame completes all 192 cycles, then busy=0, pwm=0, slot=0, and no further frame_start.
- SLOT_W=7, A=10 → slot 0 high for 22 cycles out of 128; frame length 384 cycles; slot never reads 3.
